// File: rtl/gr_file_sb.sv
// Parametrised general-register file with same-cycle write bypass and a
// per-register busy scoreboard used by decode to stall on pending results.

module gr_file_sb_rport #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                       en,
    input  logic [AW-1:0]              idx,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_n,
    input  logic [XLEN-1:0]            wd,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy,
    output logic [XLEN-1:0]            data,
    output logic                       busy_o
);
    always_comb begin
        data   = '0;
        busy_o = 1'b0;
        if (en && idx != '0) begin
            // A retiring writer is by definition the newest value and clears busy.
            if (wr_en && wr_n == idx) begin
                data = wd;
            end else begin
                data   = regs[idx];
                busy_o = busy[idx];
            end
        end
    end
endmodule

module gr_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  logic                 m_clock,
    input  logic                 rst_n,
    input  logic [NRP-1:0]       rp_en,
    input  logic [NRP*AW-1:0]    rp_n,
    output logic [NRP*XLEN-1:0]  rp_data,
    output logic [NRP-1:0]       rp_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_n,
    input  logic [XLEN-1:0]      wd,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_n,
    output logic [AW:0]          busy_cnt
);
    if ((1 << AW) != NREG || NRP < 1 || NRP > 4) begin : g_bad_param
        $error("gr_file_sb: need 2**AW == NREG and NRP in 1..4");
    end

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [AW:0]               busy_cnt_q, busy_cnt_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_en && wr_n != '0) begin
            regs_d[wr_n] = wd;
            busy_d[wr_n] = 1'b0;
        end
        // Applied after the write so a same-index reserve leaves the register busy.
        if (rsv_en && rsv_n != '0) begin
            busy_d[rsv_n] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        busy_cnt_d = '0;
        for (int i = 1; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NRP; k++) begin : g_rport
        gr_file_sb_rport #(
            .XLEN(XLEN),
            .NREG(NREG),
            .AW  (AW)
        ) u_rport (
            .en    (rp_en[k]),
            .idx   (rp_n[k*AW +: AW]),
            .wr_en (wr_en),
            .wr_n  (wr_n),
            .wd    (wd),
            .regs  (regs_q),
            .busy  (busy_q),
            .data  (rp_data[k*XLEN +: XLEN]),
            .busy_o(rp_busy[k])
        );
    end
endmodule

// File: tb/tb_gr_file_sb.sv
// Directed bench for gr_file_sb: an architectural model is checked every
// cycle, and literal expectations pin the key scenarios.

module tb_gr_file_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRP  = 2;

    logic                m_clock;
    logic                rst_n;
    logic [NRP-1:0]      rp_en;
    logic [NRP*AW-1:0]   rp_n;
    logic [NRP*XLEN-1:0] rp_data;
    logic [NRP-1:0]      rp_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_n;
    logic [XLEN-1:0]     wd;
    logic                rsv_en;
    logic [AW-1:0]       rsv_n;
    logic [AW:0]         busy_cnt;

    int checks   = 0;
    int failures = 0;
    bit clk_en   = 0;

    logic [XLEN-1:0] mreg  [NREG];
    bit              mbusy [NREG];

    gr_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP)) dut (
        .m_clock (m_clock),
        .rst_n   (rst_n),
        .rp_en   (rp_en),
        .rp_n    (rp_n),
        .rp_data (rp_data),
        .rp_busy (rp_busy),
        .wr_en   (wr_en),
        .wr_n    (wr_n),
        .wd      (wd),
        .rsv_en  (rsv_en),
        .rsv_n   (rsv_n),
        .busy_cnt(busy_cnt)
    );

    initial begin
        m_clock = 0;
        forever begin
            #5;
            if (clk_en) m_clock = ~m_clock;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural model: a plain array of values and a set of pending registers.
    always @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mreg[i]  = '0;
                mbusy[i] = 0;
            end
        end else begin
            if (wr_en && wr_n != 0) begin
                mreg[wr_n]  = wd;
                mbusy[wr_n] = 0;
            end
            if (rsv_en && rsv_n != 0) mbusy[rsv_n] = 1;
        end
    end

    always @(negedge m_clock) begin
        if (rst_n) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < NREG; i++) cnt += int'(mbusy[i]);
            chk("model_busy_cnt", 64'(busy_cnt), 64'(cnt));
            for (int k = 0; k < NRP; k++) begin
                logic [AW-1:0]   idx;
                logic [XLEN-1:0] ed;
                logic            eb;
                idx = rp_n[k*AW +: AW];
                ed  = '0;
                eb  = 0;
                if (rp_en[k] && idx != 0) begin
                    if (wr_en && wr_n == idx) ed = wd;
                    else begin
                        ed = mreg[idx];
                        eb = mbusy[idx];
                    end
                end
                chk($sformatf("model_rp_data%0d", k), 64'(rp_data[k*XLEN +: XLEN]), 64'(ed));
                chk($sformatf("model_rp_busy%0d", k), 64'(rp_busy[k]), 64'(eb));
            end
        end
    end

    task automatic idle();
        wr_en  = 0; wr_n = '0; wd = '0;
        rsv_en = 0; rsv_n = '0;
    endtask

    task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
        rp_en = 2'b11;
        rp_n  = {p1, p0};
    endtask

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    initial begin
        rst_n = 0;
        rp_en = '0;
        rp_n  = '0;
        idle();
        #3;
        // Reset with the clock stopped: every read is zero and idle.
        for (int i = 1; i < NREG; i++) begin
            rd(AW'(i), AW'(i));
            #1;
            chk("rst_data0", 64'(rp_data[31:0]), 64'h0);
            chk("rst_data1", 64'(rp_data[63:32]), 64'h0);
            chk("rst_busy", 64'(rp_busy), 64'h0);
        end
        chk("rst_cnt", 64'(busy_cnt), 64'h0);
        rst_n  = 1;
        clk_en = 1;
        tick();

        // Write and readback, x0 hard zero.
        wr_en = 1; wr_n = 5; wd = 32'hDEADBEEF;
        tick();
        idle(); rd(5, 0); #1;
        chk("wr_x5", 64'(rp_data[31:0]), 64'hDEADBEEF);
        chk("rd_x0", 64'(rp_data[63:32]), 64'h0);
        wr_en = 1; wr_n = 0; wd = 32'h1234;
        tick();
        idle(); rd(0, 0); #1;
        chk("wr_x0_dropped", 64'(rp_data[31:0]), 64'h0);

        // Bypass: port0 sees wd, port1 reading x5 is unaffected.
        wr_en = 1; wr_n = 7; wd = 32'h11111111;
        tick();
        wr_en = 1; wr_n = 7; wd = 32'hA5A5A5A5; rd(7, 5); #1;
        chk("bypass_x7", 64'(rp_data[31:0]), 64'hA5A5A5A5);
        chk("bypass_other", 64'(rp_data[63:32]), 64'hDEADBEEF);
        tick();
        idle(); rd(7, 7); #1;
        chk("after_bypass_x7", 64'(rp_data[63:32]), 64'hA5A5A5A5);

        // Scoreboard reserve / double reserve / retire.
        rsv_en = 1; rsv_n = 3;
        tick();
        idle(); rd(3, 3); #1;
        chk("rsv_busy", 64'(rp_busy), 64'h3);
        chk("rsv_cnt", 64'(busy_cnt), 64'h1);
        rsv_en = 1; rsv_n = 3;
        tick();
        idle(); #1;
        chk("rsv_again_cnt", 64'(busy_cnt), 64'h1);
        wr_en = 1; wr_n = 3; wd = 32'h55; rd(3, 0); #1;
        chk("retire_busy", 64'(rp_busy[0]), 64'h0);
        chk("retire_data", 64'(rp_data[31:0]), 64'h55);
        tick();
        idle(); #1;
        chk("retire_cnt", 64'(busy_cnt), 64'h0);

        // Simultaneous write and reserve.
        wr_en = 1; wr_n = 9; wd = 32'h99; rsv_en = 1; rsv_n = 9;
        tick();
        idle(); rd(9, 9); #1;
        chk("same_data", 64'(rp_data[31:0]), 64'h99);
        chk("same_busy", 64'(rp_busy[0]), 64'h1);
        chk("same_cnt", 64'(busy_cnt), 64'h1);
        wr_en = 1; wr_n = 9; wd = 32'h9A; rsv_en = 1; rsv_n = 10;
        tick();
        idle(); rd(9, 10); #1;
        chk("diff_busy", 64'(rp_busy), 64'h2);
        chk("diff_cnt", 64'(busy_cnt), 64'h1);
        chk("diff_data", 64'(rp_data[31:0]), 64'h9A);

        // Fill, reserve four, then async reset between edges.
        for (int i = 1; i < NREG; i++) begin
            wr_en = 1; wr_n = AW'(i); wd = 32'h01010101 * i; rd(AW'(i), AW'(i - 1));
            tick();
        end
        idle();
        for (int i = 2; i <= 8; i += 2) begin
            rsv_en = 1; rsv_n = AW'(i);
            tick();
        end
        idle(); rd(31, 17); #1;
        chk("fill_cnt", 64'(busy_cnt), 64'h4);
        chk("fill_x31", 64'(rp_data[31:0]), 64'(32'h01010101 * 31));
        wr_en = 1; wr_n = 12; wd = 32'hCAFEF00D; rsv_en = 1; rsv_n = 12;
        rst_n = 0; #1;
        chk("arst_cnt", 64'(busy_cnt), 64'h0);
        idle();
        for (int i = 1; i < NREG; i++) begin
            rd(AW'(i), AW'(NREG - i));
            #1;
            chk("arst_data", 64'(rp_data), 64'h0);
            chk("arst_busy", 64'(rp_busy), 64'h0);
        end
        #2;
        rst_n = 1;
        tick();
        rd(12, 5); #1;
        chk("arst_lost_wr", 64'(rp_data[31:0]), 64'h0);
        chk("arst_lost_rsv", 64'(rp_busy), 64'h0);
        rp_en = 2'b00; #1;
        chk("rd_disabled", 64'(rp_data), 64'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gr_file_sb.md
Name: gr_file_sb

Overview:
- Parametrised general-register file for the RV32 core. Successor of the fixed 2-read/1-write GR array.
- Generalised in data width, register count and read-port count.
- Adds same-cycle write-to-read bypass, asynchronous reset of all registers, and a per-register busy scoreboard so decode can stall on pending multi-cycle results (loads, mul/div).
- Sits between decode (read/reserve side) and writeback (write side).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers, power of two, >= 2
AW, 5, register index width, must equal log2(NREG)
NRP, 2, number of read ports, 1..4

Ports:
m_clock  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rp_en  in  NRP  read strobe per port
rp_n  in  NRP*AW  read index; port k occupies bits [k*AW +: AW]
rp_data  out  NRP*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
rp_busy  out  NRP  read register has an outstanding reservation
wr_en  in  1  writeback strobe
wr_n  in  AW  writeback index
wd  in  XLEN  writeback data
rsv_en  in  1  reserve destination for a pending multi-cycle result
rsv_n  in  AW  index to reserve
busy_cnt  out  AW+1  number of registers currently reserved

Behaviour:
- One clock, m_clock. Reset is asynchronous and active-low on rst_n.
- Reset: all NREG registers cleared to 0; all busy bits cleared; busy_cnt=0.
- Register 0 is hard zero:
  - Writes to index 0 are dropped.
  - Reservations of index 0 are dropped.
  - Reads of index 0 return 0 with rp_busy=0.
- Read (combinational, 0 latency), per port k:
  - rp_en[k]=0 -> rp_data=0, rp_busy=0.
  - Index 0 -> rp_data=0, rp_busy=0.
  - wr_en=1 and wr_n==rp_n[k], nonzero -> rp_data=wd (bypass), rp_busy=0.
  - Otherwise -> rp_data=reg[rp_n[k]], rp_busy=busy[rp_n[k]].
- Write: on rising edge with wr_en=1 and wr_n!=0, reg[wr_n]<=wd and busy[wr_n]<=0. Data visible through the array from the next cycle; visible through bypass in the same cycle.
- Reserve: on rising edge with rsv_en=1 and rsv_n!=0, busy[rsv_n]<=1.
- Simultaneous write and reserve to the same index: data is written and busy ends 1 (reserve wins; a new producer was issued as the old one retired).
- Simultaneous write and reserve to different indices: both take effect.
- Reserving an already-busy register: no change; busy_cnt does not double count.
- Writing a non-busy register: legal, busy stays 0.
- busy_cnt:
  - Registered popcount of the busy vector, updated in the same edge as busy.
  - Range 0..NREG-1; register 0 never counts.
  - Net change per edge is -1, 0 or +1.
- Multiple read ports may address the same register; each sees identical data and busy.
- Reset asserted mid-operation: immediate clear of all state regardless of m_clock; any pending write or reserve in that cycle is lost.
- Parameter check: elaboration-time error if 2**AW != NREG, or if NRP is outside 1..4.
- No X on outputs after reset for any input combination with known values.

Test Plan:
1. Reset then read: assert rst_n=0 with no clock; read x1..x31 on both ports -> rp_data=0, rp_busy=0, busy_cnt=0.
2. Write and readback: write x5=0xDEADBEEF. Next cycle read port0=x5, port1=x0 -> 0xDEADBEEF and 0. Write x0=0x1234 -> x0 still reads 0.
3. Bypass: same cycle wr_en=1, wr_n=7, wd=0xA5A5A5A5 and rp_n[0]=7 -> rp_data[0]=0xA5A5A5A5 that cycle, with x7 array value still old.
4. Scoreboard:
   - Reserve x3 -> next cycle rp_busy for x3 =1, busy_cnt=1.
   - Reserve x3 again -> busy_cnt stays 1.
   - Write x3=0x55 -> that cycle rp_busy=0 with data 0x55; next cycle busy_cnt=0.
5. Simultaneous events:
   - Write x9 and reserve x9 in one edge -> x9=wd, busy[x9]=1, busy_cnt=1.
   - Write x9 and reserve x10 in one edge -> busy x9=0, x10=1, busy_cnt=1.
6. Async reset mid-run: after filling x1..x31 and reserving 4 registers, pulse rst_n low between clock edges -> all reads return 0, rp_busy=0 and busy_cnt=0 immediately.
